// File: rtl/otter_mmio_pkg.sv
// otter_mmio_pkg: shared MMIO window constants, slot kinds and the address decoder
package otter_mmio_pkg;
  localparam logic [31:0] MMIO_BASE = 32'h1100_0000;
  localparam int SLOT_STRIDE_LOG2 = 18;
  typedef enum logic [2:0] {SLOT_IN, SLOT_OUT, SLOT_PEND, SLOT_MASK, SLOT_NONE} slot_kind_e;
  typedef struct packed {
    slot_kind_e kind;
    logic [5:0] idx;
  } slot_t;
  // Map an address to its slot kind and the index within that kind.
  // Only slot-aligned addresses inside the 64-slot window decode.
  function automatic slot_t decode(input logic [31:0] addr, input logic [31:0] base,
                                   input int stride_log2, input int num_in, input int num_out);
    int k;
    logic hit;
    slot_t s;
    k = int'((addr >> stride_log2) & 32'h3f);
    hit = ((addr >> (stride_log2 + 6)) == (base >> (stride_log2 + 6))) &&
          ((addr & ((32'd1 << stride_log2) - 32'd1)) == 32'd0);
    s.idx = 6'(k);
    s.kind = SLOT_NONE;
    if (hit) begin
      if (k < num_in) s.kind = SLOT_IN;
      else if (k < num_in + num_out) begin
        s.kind = SLOT_OUT;
        s.idx = 6'(k - num_in);
      end
      else if (k == num_in + num_out) s.kind = SLOT_PEND;
      else if (k == num_in + num_out + 1) s.kind = SLOT_MASK;
    end
    return s;
  endfunction
endpackage

// File: rtl/mmio_irq_ctrl.sv
// mmio_irq_ctrl: rising-edge capture into pending bits, W1C clear, mask and registered INTR
module mmio_irq_ctrl #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] src,
  input  logic               wr_pend,
  input  logic               wr_mask,
  input  logic [NUM_IRQ-1:0] wdata,
  output logic [NUM_IRQ-1:0] pend,
  output logic [NUM_IRQ-1:0] mask,
  output logic               intr
);
  logic [NUM_IRQ-1:0] prev, rise, clr;
  assign rise = src & ~prev;
  assign clr  = wr_pend ? wdata : '0;
  // Edge history, pending (set beats clear), mask and the registered interrupt line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev <= '0;
      pend <= '0;
      mask <= '0;
      intr <= 1'b0;
    end else begin
      prev <= src;
      pend <= (pend & ~clr) | rise;
      if (wr_mask) mask <= wdata;
      intr <= |(pend & mask);
    end
endmodule

// File: rtl/otter_mmio_hub.sv
// otter_mmio_hub: generic IOBUS slot hub (inputs, outputs with strobes, IRQ block).
// Define MMIO_IN_SYNC_EN to pass IN_DATA and IRQ_SRC through two-flop synchronisers.
module otter_mmio_hub
  import otter_mmio_pkg::*;
#(
  parameter int          NUM_IN      = 4,
  parameter int          NUM_OUT     = 6,
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] BASE_ADDR   = MMIO_BASE,
  parameter int          STRIDE_LOG2 = SLOT_STRIDE_LOG2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [31:0]           IOBUS_ADDR,
  input  logic [31:0]           IOBUS_OUT,
  input  logic                  IOBUS_WR,
  output logic [31:0]           IOBUS_IN,
  input  logic [NUM_IN*32-1:0]  IN_DATA,
  output logic [NUM_OUT*32-1:0] OUT_DATA,
  output logic [NUM_OUT-1:0]    OUT_WSTB,
  input  logic [NUM_IRQ-1:0]    IRQ_SRC,
  output logic                  INTR
);
  if (NUM_IN + NUM_OUT + 2 > 64) begin : g_bad_map
    $error("otter_mmio_hub: NUM_IN+NUM_OUT+2 must not exceed 64 slots");
  end
  slot_t dec;
  logic wr_out;
  logic [NUM_IN*32-1:0] in_use;
  logic [NUM_IRQ-1:0] irq_use, pend, mask;
  assign dec    = decode(IOBUS_ADDR, BASE_ADDR, STRIDE_LOG2, NUM_IN, NUM_OUT);
  assign wr_out = IOBUS_WR && dec.kind == SLOT_OUT;
`ifdef MMIO_IN_SYNC_EN
  logic [NUM_IN*32-1:0] in_s1, in_s2;
  logic [NUM_IRQ-1:0] irq_s1, irq_s2;
  // Two-flop synchronisers for asynchronous board inputs and interrupt sources
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      in_s1  <= '0;
      in_s2  <= '0;
      irq_s1 <= '0;
      irq_s2 <= '0;
    end else begin
      in_s1  <= IN_DATA;
      in_s2  <= in_s1;
      irq_s1 <= IRQ_SRC;
      irq_s2 <= irq_s1;
    end
  assign in_use  = in_s2;
  assign irq_use = irq_s2;
`else
  assign in_use  = IN_DATA;
  assign irq_use = IRQ_SRC;
`endif
  // Output registers capture the store; the strobe marks the cycle after it
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      OUT_DATA <= '0;
      OUT_WSTB <= '0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        OUT_WSTB[j] <= wr_out && dec.idx == 6'(j);
        if (wr_out && dec.idx == 6'(j)) OUT_DATA[j*32 +: 32] <= IOBUS_OUT;
      end
    end
  // Same-cycle read mux; anything unmapped reads as zero
  always_comb begin
    IOBUS_IN = '0;
    for (int j = 0; j < NUM_IN; j++)
      if (dec.kind == SLOT_IN && dec.idx == 6'(j)) IOBUS_IN = in_use[j*32 +: 32];
    for (int j = 0; j < NUM_OUT; j++)
      if (dec.kind == SLOT_OUT && dec.idx == 6'(j)) IOBUS_IN = OUT_DATA[j*32 +: 32];
    if (dec.kind == SLOT_PEND) IOBUS_IN = 32'(pend);
    if (dec.kind == SLOT_MASK) IOBUS_IN = 32'(mask);
  end
  mmio_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .src     (irq_use),
    .wr_pend (IOBUS_WR && dec.kind == SLOT_PEND),
    .wr_mask (IOBUS_WR && dec.kind == SLOT_MASK),
    .wdata   (IOBUS_OUT[NUM_IRQ-1:0]),
    .pend    (pend),
    .mask    (mask),
    .intr    (INTR)
  );
endmodule

// File: tb/tb_otter_mmio_hub.sv
// tb_otter_mmio_hub: directed stimulus with a cycle-stamped scoreboard checked by a monitor
module tb_otter_mmio_hub;
  localparam logic [31:0] A_IN0  = 32'h1100_0000;
  localparam logic [31:0] A_IN2  = 32'h1108_0000;
  localparam logic [31:0] A_OUT0 = 32'h1110_0000;
  localparam logic [31:0] A_OUT1 = 32'h1114_0000;
  localparam logic [31:0] A_OUT5 = 32'h1124_0000;
  localparam logic [31:0] A_PEND = 32'h1128_0000;
  localparam logic [31:0] A_MASK = 32'h112C_0000;
  localparam logic [31:0] A_UNM  = 32'h11FC_0000;
`ifdef MMIO_IN_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif
  localparam int T_RD = 0, T_OUT = 1, T_WSTB = 2, T_INTR = 3;
  logic clk = 1'b0;
  logic RESET_N;
  logic [31:0] IOBUS_ADDR, IOBUS_OUT, IOBUS_IN;
  logic IOBUS_WR, INTR;
  logic [127:0] IN_DATA;
  logic [191:0] OUT_DATA;
  logic [5:0] OUT_WSTB;
  logic [3:0] IRQ_SRC;
  typedef struct {
    string       name;
    int          tag;
    int          idx;
    logic [31:0] val;
    int          cyc;
  } item_t;
  item_t sb[$];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  otter_mmio_hub dut (
    .CLK(clk), .RESET_N(RESET_N), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .IN_DATA(IN_DATA), .OUT_DATA(OUT_DATA),
    .OUT_WSTB(OUT_WSTB), .IRQ_SRC(IRQ_SRC), .INTR(INTR)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: at each falling edge, check every expectation stamped for this cycle
  always @(negedge clk) begin : mon
    item_t it;
    logic [31:0] obs;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      obs = it.tag == T_RD ? IOBUS_IN :
            it.tag == T_OUT ? OUT_DATA[it.idx*32 +: 32] :
            it.tag == T_WSTB ? 32'(OUT_WSTB) : 32'(INTR);
      n_vec++;
      if (it.cyc != cyc || obs !== it.val) begin
        n_err++;
        $display("FAIL %s: got %h want %h (cycle %0d, due %0d)", it.name, obs, it.val, cyc, it.cyc);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int tag, input int idx, input logic [31:0] v, input int at);
    sb.push_back('{nm, tag, idx, v, cyc + at});
  endtask
  initial begin
    RESET_N = 1'b0;
    IOBUS_ADDR = '0;
    IOBUS_OUT = '0;
    IOBUS_WR = 1'b0;
    IRQ_SRC = 4'hF;
    IN_DATA = {32'h3333_3333, 32'h0000_A5A5, 32'h2222_2222, 32'h1111_1111};
    tick();
    chk("rst_intr", T_INTR, 0, 0, 0);
    chk("rst_wstb", T_WSTB, 0, 0, 0);
    chk("rst_out0", T_OUT, 0, 0, 0);
    chk("rst_out5", T_OUT, 5, 0, 0);
    tick();
    RESET_N = 1'b1;
    IRQ_SRC = 4'h0;
    IOBUS_ADDR = A_PEND;
    chk("rel_pend", T_RD, 0, 0, 1 + L);
    chk("rel_intr", T_INTR, 0, 0, 2 + L);
    repeat (3 + L) tick();
    IOBUS_ADDR = A_OUT0;
    IOBUS_OUT = 32'hDEAD_BEEF;
    IOBUS_WR = 1'b1;
    chk("wstb_pre", T_WSTB, 0, 0, 0);
    tick();
    IOBUS_WR = 1'b0;
    chk("out0", T_OUT, 0, 32'hDEAD_BEEF, 0);
    chk("wstb0", T_WSTB, 0, 32'h1, 0);
    chk("rd_out0", T_RD, 0, 32'hDEAD_BEEF, 0);
    chk("wstb0_off", T_WSTB, 0, 0, 1);
    tick();
    IOBUS_ADDR = A_OUT1;
    IOBUS_OUT = 32'hCAFE_0001;
    IOBUS_WR = 1'b1;
    tick();
    IOBUS_ADDR = A_OUT5;
    IOBUS_OUT = 32'h0000_0055;
    chk("b2b_wstb1", T_WSTB, 0, 32'h02, 0);
    tick();
    IOBUS_WR = 1'b0;
    chk("b2b_wstb5", T_WSTB, 0, 32'h20, 0);
    chk("out1", T_OUT, 1, 32'hCAFE_0001, 0);
    chk("out5", T_OUT, 5, 32'h0000_0055, 0);
    tick();
    chk("b2b_idle", T_WSTB, 0, 0, 0);
    IOBUS_ADDR = A_IN0;
    IOBUS_OUT = 32'hFFFF_FFFF;
    IOBUS_WR = 1'b1;
    tick();
    chk("ign_in_wstb", T_WSTB, 0, 0, 0);
    chk("ign_in_out0", T_OUT, 0, 32'hDEAD_BEEF, 0);
    IOBUS_ADDR = A_UNM;
    tick();
    IOBUS_WR = 1'b0;
    chk("ign_unm_wstb", T_WSTB, 0, 0, 0);
    chk("ign_unm_out5", T_OUT, 5, 32'h0000_0055, 0);
    chk("rd_unm", T_RD, 0, 0, 0);
    tick();
    IOBUS_ADDR = 32'h1100_0004;
    chk("rd_mis_in0", T_RD, 0, 0, 0);
    tick();
    IOBUS_ADDR = 32'h1110_0004;
    chk("rd_mis_out0", T_RD, 0, 0, 0);
    tick();
    IOBUS_ADDR = 32'h1010_0000;
    chk("rd_off_window", T_RD, 0, 0, 0);
    tick();
    IOBUS_ADDR = A_IN2;
    chk("rd_in2", T_RD, 0, 32'h0000_A5A5, 0);
    tick();
    IOBUS_ADDR = A_IN0;
    chk("rd_in0", T_RD, 0, 32'h1111_1111, 0);
    tick();
    IOBUS_ADDR = A_OUT1;
    chk("rd_out1", T_RD, 0, 32'hCAFE_0001, 0);
    tick();
    IOBUS_ADDR = A_MASK;
    IOBUS_OUT = 32'h2;
    IOBUS_WR = 1'b1;
    tick();
    IOBUS_WR = 1'b0;
    chk("rd_mask", T_RD, 0, 32'h2, 0);
    tick();
    IOBUS_ADDR = A_PEND;
    IRQ_SRC = 4'b0010;
    chk("irq_pend_pre", T_RD, 0, 0, 0);
    chk("irq_pend", T_RD, 0, 32'h2, 1 + L);
    chk("irq_intr_lag", T_INTR, 0, 0, 1 + L);
    chk("irq_intr", T_INTR, 0, 1, 2 + L);
    tick();
    IRQ_SRC = 4'b0000;
    repeat (2 + L) tick();
    IOBUS_OUT = 32'h2;
    IOBUS_WR = 1'b1;
    tick();
    IOBUS_WR = 1'b0;
    chk("w1c_pend", T_RD, 0, 0, 0);
    chk("w1c_intr_lag", T_INTR, 0, 1, 0);
    chk("w1c_intr", T_INTR, 0, 0, 1);
    repeat (2) tick();
    IRQ_SRC = 4'b0001;
    repeat (L) tick();
    IOBUS_OUT = 32'h1;
    IOBUS_WR = 1'b1;
    tick();
    IOBUS_WR = 1'b0;
    chk("coll_pend", T_RD, 0, 32'h1, 0);
    chk("coll_masked_intr", T_INTR, 0, 0, 1);
    tick();
    IOBUS_WR = 1'b1;
    tick();
    IOBUS_WR = 1'b0;
    IRQ_SRC = 4'b0000;
    chk("clr_pend", T_RD, 0, 0, 0);
    tick();
    IOBUS_ADDR = A_OUT0;
    IOBUS_OUT = 32'h0000_0077;
    IOBUS_WR = 1'b1;
    #2 RESET_N = 1'b0;
    chk("rst_mid_out0", T_OUT, 0, 0, 0);
    chk("rst_mid_wstb", T_WSTB, 0, 0, 0);
    tick();
    IOBUS_WR = 1'b0;
    IRQ_SRC = 4'hF;
    IOBUS_ADDR = A_MASK;
    chk("rst_mid_out0_b", T_OUT, 0, 0, 0);
    chk("rst_mid_mask", T_RD, 0, 0, 0);
    chk("rst_mid_out1", T_OUT, 1, 0, 0);
    tick();
    RESET_N = 1'b1;
    IOBUS_ADDR = A_PEND;
    chk("rel_src_pend", T_RD, 0, 32'hF, 1 + L);
    chk("rel_src_masked", T_INTR, 0, 0, 2 + L);
    repeat (3 + L) tick();
    IOBUS_ADDR = A_MASK;
    IOBUS_OUT = 32'hF;
    IOBUS_WR = 1'b1;
    tick();
    IOBUS_WR = 1'b0;
    chk("unmask_intr_lag", T_INTR, 0, 0, 0);
    chk("unmask_intr", T_INTR, 0, 1, 1);
    repeat (4) tick();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
